// File: rtl/boot_pkg.sv
// ============================================================================
// Module      : boot_pkg
// Description : Shared types and constants for the instruction-memory boot
//               loader (FSM states, word geometry, image field order).
//               BOOT_CHECKSUM_EN adds the checksum state.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package boot_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    S_PC   = 3'd0,
    S_CNT  = 3'd1,
    S_LOAD = 3'd2,
`ifdef BOOT_CHECKSUM_EN
    S_CSUM = 3'd3,
`endif
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_e;

  // Fields are listed in the order they appear in the image stream.
  typedef enum logic [1:0] {
    FIELD_PC      = 2'd0,
    FIELD_COUNT   = 2'd1,
    FIELD_PAYLOAD = 2'd2,
    FIELD_CSUM    = 2'd3
  } field_e;

  function automatic logic isReceiving(input state_e s);
    return (s != S_DONE) && (s != S_ERR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/imem_boot_loader_if.sv
// ============================================================================
// Module      : imem_boot_loader_if
// Description : Byte-stream input, instruction-memory write port and core
//               control bundle of the boot loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface imem_boot_loader_if #(
  parameter int IMEM_ADDR_W = 8
);
  logic [7:0]             RxData;
  logic                   RxValid;
  logic                   RxReady;
  logic                   ImemWrEn;
  logic [IMEM_ADDR_W-1:0] ImemAddr;
  logic [31:0]            ImemWrData;
  logic                   CoreReset_L;
  logic [31:0]            StartPC;
  logic                   Busy;
  logic                   Error;

  // Host / environment side: sources the image, observes everything else.
  modport master (
    output RxData, RxValid,
    input  RxReady, ImemWrEn, ImemAddr, ImemWrData, CoreReset_L, StartPC, Busy, Error
  );

  // Loader side.
  modport slave (
    input  RxData, RxValid,
    output RxReady, ImemWrEn, ImemAddr, ImemWrData, CoreReset_L, StartPC, Busy, Error
  );
endinterface

`default_nettype wire

// File: rtl/byte_word_assembler.sv
// ============================================================================
// Module      : byte_word_assembler
// Description : Packs big-endian bytes into 32-bit words; word_valid pulses
//               combinationally with the byte that completes a word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_word_assembler
  import boot_pkg::*;
(
  input  wire         Clk,
  input  wire         Reset_L,
  input  wire         byteValid,
  input  wire  [7:0]  byteData,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [BYTE_CNT_W-1:0] r_byteCnt;
  logic [23:0]           r_shift;

  // Counter wraps naturally from 3 to 0 as each word completes.
  always_ff @(posedge Clk or negedge Reset_L) begin
    if (!Reset_L) begin
      r_byteCnt <= '0;
      r_shift   <= '0;
    end else if (byteValid) begin
      r_byteCnt <= r_byteCnt + 1'b1;
      r_shift   <= {r_shift[15:0], byteData};
    end
  end

  assign word_valid = byteValid && (r_byteCnt == BYTE_CNT_W'(BYTES_PER_WORD - 1));
  assign word       = {r_shift, byteData};

endmodule

`default_nettype wire

// File: rtl/imem_boot_loader.sv
// ============================================================================
// Module      : imem_boot_loader
// Description : Loads a byte-serial program image into instruction memory,
//               then releases the core. Define BOOT_CHECKSUM_EN for checksum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int IMEM_ADDR_W = 8
) (
  input wire                Clk,
  input wire                Reset_L,
  imem_boot_loader_if.slave bus
);

  localparam logic [32:0] MAX_WORDS = 33'(1) << IMEM_ADDR_W;
`ifdef BOOT_CHECKSUM_EN
  localparam state_e POST_LOAD = S_CSUM;
`else
  localparam state_e POST_LOAD = S_DONE;
`endif

  state_e                 r_state;
  state_e                 w_nextState;
  logic                   r_active;
  logic                   r_wrEn;
  logic [IMEM_ADDR_W-1:0] r_addr;
  logic [31:0]            r_wrData;
  logic                   r_coreRst_L;
  logic [31:0]            r_startPC;
  logic [IMEM_ADDR_W:0]   r_wordCnt;
  logic [IMEM_ADDR_W:0]   r_idx;
  logic                   w_accept;
  logic                   w_wordValid;
  logic [31:0]            w_word;
  logic                   w_lastWord;
  logic                   w_latchPC;
  logic                   w_latchN;
  logic                   w_loadWrite;
  logic                   w_error;
`ifdef BOOT_CHECKSUM_EN
  logic [31:0]            r_sum;
`endif

  assign w_accept   = bus.RxValid && r_active;
  assign w_lastWord = (r_idx == r_wordCnt - 1'b1);

  byte_word_assembler u_asm (
    .Clk        (Clk),
    .Reset_L    (Reset_L),
    .byteValid  (w_accept),
    .byteData   (bus.RxData),
    .word_valid (w_wordValid),
    .word       (w_word)
  );

  always_ff @(posedge Clk or negedge Reset_L) begin
    if (!Reset_L) r_state <= S_PC;
    else          r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_PC: if (w_wordValid)
        w_nextState = (w_word[1:0] != 2'b00) ? S_ERR : S_CNT;
      S_CNT: if (w_wordValid) begin
        if ({1'b0, w_word} > MAX_WORDS) w_nextState = S_ERR;
        else if (w_word == 32'd0)       w_nextState = POST_LOAD;
        else                            w_nextState = S_LOAD;
      end
      S_LOAD: if (w_wordValid && w_lastWord) w_nextState = POST_LOAD;
`ifdef BOOT_CHECKSUM_EN
      S_CSUM: if (w_wordValid)
        w_nextState = (w_word == r_sum) ? S_DONE : S_ERR;
`endif
      default: w_nextState = r_state;
    endcase
  end

  always_comb begin
    w_latchPC   = 1'b0;
    w_latchN    = 1'b0;
    w_loadWrite = 1'b0;
    w_error     = 1'b0;
    case (r_state)
      S_PC:    w_latchPC   = w_wordValid;
      S_CNT:   w_latchN    = w_wordValid;
      S_LOAD:  w_loadWrite = w_wordValid;
      S_ERR:   w_error     = 1'b1;
      default: ;
    endcase
  end

  // Ready/busy follow the next state so they drop with the final field byte.
  always_ff @(posedge Clk or negedge Reset_L) begin
    if (!Reset_L) begin
      r_active    <= 1'b0;
      r_wrEn      <= 1'b0;
      r_addr      <= '0;
      r_wrData    <= '0;
      r_coreRst_L <= 1'b0;
      r_startPC   <= '0;
      r_wordCnt   <= '0;
      r_idx       <= '0;
    end else begin
      r_active    <= isReceiving(w_nextState);
      r_wrEn      <= w_loadWrite;
      r_coreRst_L <= (r_state == S_DONE);
      if (w_latchPC) r_startPC <= w_word;
      if (w_latchN)  r_wordCnt <= w_word[IMEM_ADDR_W:0];
      if (w_loadWrite) begin
        r_addr   <= r_startPC[IMEM_ADDR_W+1:2] + r_idx[IMEM_ADDR_W-1:0];
        r_wrData <= w_word;
        r_idx    <= r_idx + 1'b1;
      end
    end
  end

`ifdef BOOT_CHECKSUM_EN
  always_ff @(posedge Clk or negedge Reset_L) begin
    if (!Reset_L)         r_sum <= '0;
    else if (w_loadWrite) r_sum <= r_sum + w_word;
  end
`endif

  assign bus.RxReady     = r_active;
  assign bus.Busy        = r_active;
  assign bus.ImemWrEn    = r_wrEn;
  assign bus.ImemAddr    = r_addr;
  assign bus.ImemWrData  = r_wrData;
  assign bus.CoreReset_L = r_coreRst_L;
  assign bus.StartPC     = r_startPC;
  assign bus.Error       = w_error;

endmodule

`default_nettype wire

// File: doc/imem_boot_loader.md
# imem_boot_loader

Byte-serial boot loader sitting directly upstream of the single-cycle processor core. It receives a program image over a valid/ready byte stream and writes it word-by-word into the instruction memory's write port. It holds the core in reset while loading, then supplies the core's `startPC` and releases the core's active-low reset. It is the only agent that writes instruction memory.

## Interface
Parameters:
- `IMEM_ADDR_W`, default 8: instruction-memory word-address width; capacity is 2^IMEM_ADDR_W words.

Ports:
- `Clk` — in, 1: clock; all state updates on posedge.
- `Reset_L` — in, 1: reset; asynchronous, active-low.
- `RxData` — in, 8: image byte.
- `RxValid` — in, 1: `RxData` is valid.
- `RxReady` — out, 1: loader accepts a byte; transfer occurs when `RxValid` & `RxReady` at posedge.
- `ImemWrEn` — out, 1: one-cycle instruction-memory write strobe.
- `ImemAddr` — out, IMEM_ADDR_W: word address for the write.
- `ImemWrData` — out, 32: word to write.
- `CoreReset_L` — out, 1: drives the core's `Reset_L`; low until the load completes successfully.
- `StartPC` — out, 32: drives the core's `startPC`.
- `Busy` — out, 1: high in S_PC, S_CNT, S_LOAD, and S_CSUM.
- `Error` — out, 1: sticky; high in S_ERR.

## Operation
- Image format, all fields big-endian (first byte = bits 31:24):
  - 4-byte start PC P.
  - 4-byte word count N.
  - N 4-byte payload words.
  - With `BOOT_CHECKSUM_EN` only: a 4-byte checksum.
- FSM states: S_PC → S_CNT → S_LOAD → (S_CSUM) → S_DONE; any state may go to S_ERR.
- A 2-bit byte counter assembles each word in a 32-bit shift register. The counter wraps 3→0 on each completed field word.
- **S_PC:** on the 4th byte, latch P into the `StartPC` register.
  - If P[1:0] ≠ 0, go to S_ERR.
  - Otherwise go to S_CNT.
- **S_CNT:** on the 4th byte, latch N.
  - If N > 2^IMEM_ADDR_W, go to S_ERR.
  - If N = 0, go to S_CSUM (macro on) or S_DONE (macro off).
  - Otherwise go to S_LOAD. Word index i = 0.
- **S_LOAD:** on the 4th byte of each word, register the write:
  - `ImemWrData` = assembled word.
  - `ImemAddr` = (P[IMEM_ADDR_W+1:2] + i) mod 2^IMEM_ADDR_W (wraps).
  - `ImemWrEn` = 1 for exactly one cycle.
  - After word N−1, go to S_CSUM (macro on) or S_DONE (macro off).
- **S_DONE:** `RxReady` = 0, `CoreReset_L` = 1, `StartPC` held. The state is terminal.
- **S_ERR:** `RxReady` = 0, `CoreReset_L` = 0, `Error` = 1. The state is terminal.
- Leaving S_DONE or S_ERR requires `Reset_L`.
- Word index counter width is IMEM_ADDR_W+1 bits. The N comparison uses the full 32-bit N.

## Timing
- Reset values:
  - `RxReady` = 0, `ImemWrEn` = 0, `ImemAddr` = 0, `ImemWrData` = 0.
  - `CoreReset_L` = 0, `StartPC` = 0, `Busy` = 0, `Error` = 0.
  - State = S_PC, all counters 0.
- `RxReady` and `Busy` rise on the first posedge after `Reset_L` deasserts. `RxReady` is registered.
- `RxReady` stays 1 through all receiving states. It drops in the same cycle the FSM enters S_DONE or S_ERR, so no byte is accepted after the final field byte.
- Backpressure-free: one byte is accepted per cycle when `RxValid` = 1. Gaps in `RxValid` stall assembly with no state change.
- Write latency: `ImemWrEn` is high in the cycle after the posedge that accepted the word's 4th byte. `ImemAddr` and `ImemWrData` are valid only while `ImemWrEn` = 1.
- `CoreReset_L` rises on the posedge after the final write strobe has completed, i.e. the core sees its first instruction fetch from fully written memory. With the macro on, it rises on the posedge after the last checksum byte.
- `StartPC` is stable whenever `CoreReset_L` = 0→1 transitions occur.
- Reset mid-load: all registers clear immediately (asynchronous) and `CoreReset_L` goes low. Instruction-memory contents are not cleared; a new image overwrites them.

## Configuration
- `BOOT_CHECKSUM_EN` defined:
  - S_CSUM state present; a 32-bit running sum of payload words (mod 2^32) is kept.
  - After the checksum field is received: match → S_DONE, mismatch → S_ERR.
  - N = 0 expects checksum 0.
- `BOOT_CHECKSUM_EN` undefined: no S_CSUM state, no sum register; the image ends after the payload.

## Structure
- The shared package `boot_pkg` holds the state enumeration, the byte-per-word constant (4), and the image field order.
- One sub-module, `byte_word_assembler`: byte counter plus shift register, emitting a one-cycle `word_valid` with the 32-bit word. It is reused for every field.

## Test plan
- Image P = 0x00000010, N = 3, words 0xAABBCCDD, 0x11223344, 0x8C000000, macro off:
  - Writes go to ImemAddr 4, 5, 6 with matching data, one strobe each.
  - `CoreReset_L` rises one cycle after the 3rd strobe; `StartPC` = 0x10.
- Same image with `RxValid` toggled every other cycle → identical writes and addresses, only later in time.
- P = 0x00000012 → `Error` = 1 after the 4th byte; no `ImemWrEn`; `CoreReset_L` stays 0; `RxReady` = 0.
- IMEM_ADDR_W = 8, P = 0x3F8, N = 4 → addresses 254, 255, 0, 1 (wrap).
- IMEM_ADDR_W = 8, N = 257 → S_ERR after the count field, with no writes.
- `Reset_L` pulsed after 2 of 3 words, then the full image is resent → writes restart at the base address and `CoreReset_L` is low throughout the reset.
- Macro on, N = 2, words 1 and 2:
  - Checksum 3 → `CoreReset_L` = 1.
  - Checksum 4 → `Error` = 1 and `CoreReset_L` = 0.
